// File: rtl/pe_sched.sv
// Job scheduler for a PE array: latches a job shape, sequences the PE strobes and
// moves weight, feature and psum words from valid-only sources into the PE.
module pe_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int PARA_WIDTH = 8,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_start,
  input  logic [PARA_WIDTH-1:0] cfg_S,
  input  logic [PARA_WIDTH-1:0] cfg_U,
  input  logic [PARA_WIDTH-1:0] cfg_q,
  input  logic [PARA_WIDTH-1:0] cfg_p,
  input  logic [PARA_WIDTH-1:0] cfg_j,
  input  logic [PARA_WIDTH-1:0] cfg_k,
  input  logic                  cfg_mode,
  input  logic [PARA_WIDTH-1:0] cfg_n_slides,
  input  logic                  fmap_src_valid,
  input  logic [DATA_WIDTH-1:0] fmap_src_data,
  output logic                  fmap_src_ready,
  input  logic                  wgt_src_valid,
  input  logic [DATA_WIDTH-1:0] wgt_src_data,
  output logic                  wgt_src_ready,
  input  logic                  psum_src_valid,
  input  logic [DATA_WIDTH-1:0] psum_src_data,
  output logic                  psum_src_ready,
  output logic [PARA_WIDTH-1:0] S,
  output logic [PARA_WIDTH-1:0] U,
  output logic [PARA_WIDTH-1:0] q,
  output logic [PARA_WIDTH-1:0] p,
  output logic [PARA_WIDTH-1:0] j,
  output logic [PARA_WIDTH-1:0] k,
  output logic                  mode,
  output logic                  start_config,
  output logic                  start_weight_load,
  output logic                  start_feature_load,
  output logic                  start_psum_in_load,
  output logic                  psum_out_start,
  output logic                  load_full_cloumn,
  output logic [DATA_WIDTH-1:0] feature_in,
  output logic                  feature_in_en,
  output logic [DATA_WIDTH-1:0] weight_in,
  output logic                  weight_in_en,
  output logic [DATA_WIDTH-1:0] psum_in,
  output logic                  psum_in_en,
  input  logic                  fifo_full_fmap,
  input  logic                  fifo_full_filter,
  input  logic                  mac_finish,
  input  logic                  psum_acc_finish,
  input  logic                  psum_out_valid,
  output logic                  busy,
  output logic                  job_done,
  output logic                  cfg_err
);

  typedef enum logic [3:0] {
    IDLE, CFG, WSTART, WLOAD, FSTART, FLOAD, WMAC,
    PSTART, PLOAD, WACC, OSTART, WOUT, DONE
  } state_t;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  cnt, cnt_next, cnt_inc, target;
  logic [PARA_WIDTH-1:0] slide, slide_next, n_slides;
  logic                  cfg_ok, latch_cfg, reject, xfer, load_last;

  // Enables are gated by rst so nothing is handed to the PE during a reset cycle.
  assign weight_in_en  = rst && (state == WLOAD) && wgt_src_valid && !fifo_full_filter;
  assign feature_in_en = rst && (state == FLOAD) && fmap_src_valid && !fifo_full_fmap;
  assign psum_in_en    = rst && (state == PLOAD) && psum_src_valid;

  assign wgt_src_ready  = weight_in_en;
  assign fmap_src_ready = feature_in_en;
  assign psum_src_ready = psum_in_en;

  assign weight_in  = wgt_src_data;
  assign feature_in = fmap_src_data;
  assign psum_in    = psum_src_data;

  assign start_config       = (state == CFG);
  assign start_weight_load  = (state == WSTART);
  assign start_feature_load = (state == FSTART);
  assign start_psum_in_load = (state == PSTART);
  assign psum_out_start     = (state == OSTART);
  assign job_done           = (state == DONE);
  assign busy               = (state != IDLE);

  assign cfg_ok = (cfg_S != '0) && (cfg_U != '0) && (cfg_q != '0) &&
                  (cfg_p != '0) && (cfg_n_slides != '0);

  // The first window loads S columns; later windows only the U new columns.
  always_comb begin
    target = '0;
    case (state)
      WLOAD:   target = CNT_WIDTH'(S) * CNT_WIDTH'(q) * CNT_WIDTH'(p);
      FLOAD:   target = (slide == '0) ? CNT_WIDTH'(S) * CNT_WIDTH'(q)
                                      : CNT_WIDTH'(U) * CNT_WIDTH'(q);
      PLOAD:   target = CNT_WIDTH'(p);
      default: target = '0;
    endcase
  end

  assign xfer      = weight_in_en || feature_in_en || psum_in_en;
  assign cnt_inc   = cnt + CNT_WIDTH'(1);
  assign load_last = xfer && (cnt_inc == target);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_next = state;
    slide_next = slide;
    cnt_next   = cnt;
    latch_cfg  = 1'b0;
    reject     = 1'b0;
    if (xfer) cnt_next = load_last ? '0 : cnt_inc;
    case (state)
      IDLE: begin
        if (job_start) begin
          if (cfg_ok) begin
            latch_cfg  = 1'b1;
            slide_next = '0;
            state_next = CFG;
          end else begin
            reject = 1'b1;
          end
        end
      end
      CFG:    state_next = WSTART;
      WSTART: state_next = WLOAD;
      WLOAD:  if (load_last) state_next = FSTART;
      FSTART: state_next = FLOAD;
      FLOAD:  if (load_last) state_next = WMAC;
      WMAC:   if (mac_finish) state_next = mode ? PSTART : OSTART;
      PSTART: state_next = PLOAD;
      PLOAD:  if (load_last) state_next = WACC;
      WACC:   if (psum_acc_finish) state_next = OSTART;
      OSTART: state_next = WOUT;
      WOUT: begin
        if (psum_out_valid) begin
          if (slide == n_slides - PARA_WIDTH'(1)) begin
            state_next = DONE;
          end else begin
            slide_next = slide + PARA_WIDTH'(1);
            state_next = FSTART;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      slide            <= '0;
      n_slides         <= '0;
      S                <= '0;
      U                <= '0;
      q                <= '0;
      p                <= '0;
      j                <= '0;
      k                <= '0;
      mode             <= 1'b0;
      load_full_cloumn <= 1'b0;
      cfg_err          <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      slide   <= slide_next;
      cfg_err <= reject;
      load_full_cloumn <= ((state_next == FSTART) || (state_next == FLOAD)) &&
                          (slide_next == '0);
      if (latch_cfg) begin
        S        <= cfg_S;
        U        <= cfg_U;
        q        <= cfg_q;
        p        <= cfg_p;
        j        <= cfg_j;
        k        <= cfg_k;
        mode     <= cfg_mode;
        n_slides <= cfg_n_slides;
      end
    end
  end

endmodule

// File: tb/tb_pe_sched.sv
// Directed bench for pe_sched: table of whole jobs with hand-computed totals,
// plus hand-written sequences for reset mid-load and stray/awaited mac_finish.
module tb_pe_sched;
  localparam int DW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_start;
  logic [PW-1:0] cfg_S, cfg_U, cfg_q, cfg_p, cfg_j, cfg_k, cfg_n_slides;
  logic          cfg_mode;
  logic          fmap_src_valid, wgt_src_valid, psum_src_valid;
  logic [DW-1:0] fmap_src_data, wgt_src_data, psum_src_data;
  logic          fmap_src_ready, wgt_src_ready, psum_src_ready;
  logic [PW-1:0] S, U, q, p, j, k;
  logic          mode;
  logic          start_config, start_weight_load, start_feature_load;
  logic          start_psum_in_load, psum_out_start, load_full_cloumn;
  logic [DW-1:0] feature_in, weight_in, psum_in;
  logic          feature_in_en, weight_in_en, psum_in_en;
  logic          fifo_full_fmap, fifo_full_filter;
  logic          mac_finish, psum_acc_finish, psum_out_valid;
  logic          busy, job_done, cfg_err;

  pe_sched dut (
    .clk(clk), .rst(rst), .job_start(job_start),
    .cfg_S(cfg_S), .cfg_U(cfg_U), .cfg_q(cfg_q), .cfg_p(cfg_p), .cfg_j(cfg_j), .cfg_k(cfg_k),
    .cfg_mode(cfg_mode), .cfg_n_slides(cfg_n_slides),
    .fmap_src_valid(fmap_src_valid), .fmap_src_data(fmap_src_data), .fmap_src_ready(fmap_src_ready),
    .wgt_src_valid(wgt_src_valid), .wgt_src_data(wgt_src_data), .wgt_src_ready(wgt_src_ready),
    .psum_src_valid(psum_src_valid), .psum_src_data(psum_src_data), .psum_src_ready(psum_src_ready),
    .S(S), .U(U), .q(q), .p(p), .j(j), .k(k), .mode(mode),
    .start_config(start_config), .start_weight_load(start_weight_load),
    .start_feature_load(start_feature_load), .start_psum_in_load(start_psum_in_load),
    .psum_out_start(psum_out_start), .load_full_cloumn(load_full_cloumn),
    .feature_in(feature_in), .feature_in_en(feature_in_en),
    .weight_in(weight_in), .weight_in_en(weight_in_en),
    .psum_in(psum_in), .psum_in_en(psum_in_en),
    .fifo_full_fmap(fifo_full_fmap), .fifo_full_filter(fifo_full_filter),
    .mac_finish(mac_finish), .psum_acc_finish(psum_acc_finish), .psum_out_valid(psum_out_valid),
    .busy(busy), .job_done(job_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s, u, qq, pp, m, n, bp;                       // job inputs
    int w, ff, fp, ps, pst, ost, done, err;           // expected totals
  } job_t;

  job_t vec[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Per-job tallies, gathered at the falling edge.
  int n_w, n_ff, n_fp, n_ps, n_pst, n_ost, n_done, n_err_p, n_cfg;
  int n_fs_l, n_fs_n, n_busy, n_bpv, rdy_bad, f_bad, f_exp, w_last, p_last;
  int f_seq, w_seq, p_seq;
  logic bp_on;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_w = 0; n_ff = 0; n_fp = 0; n_ps = 0; n_pst = 0; n_ost = 0; n_done = 0;
    n_err_p = 0; n_cfg = 0; n_fs_l = 0; n_fs_n = 0; n_busy = 0; n_bpv = 0;
    rdy_bad = 0; f_bad = 0; f_exp = 1; w_last = 0; p_last = 0;
    f_seq = 1; w_seq = 1; p_seq = 1;
    fmap_src_data = DW'(f_seq); wgt_src_data = DW'(w_seq); psum_src_data = DW'(p_seq);
  endtask

  // One clock: optionally toggle fmap backpressure, observe at negedge, advance sources after posedge.
  task automatic step();
    logic tw, tf, tp;
    if (bp_on) fifo_full_fmap = ~fifo_full_fmap;
    @(negedge clk);
    tw = weight_in_en; tf = feature_in_en; tp = psum_in_en;
    if (weight_in_en) begin n_w++; w_last = int'(weight_in); end
    if (feature_in_en) begin
      if (load_full_cloumn) n_ff++; else n_fp++;
      if (feature_in != DW'(f_exp)) f_bad++;
      f_exp++;
      if (fifo_full_fmap) n_bpv++;
    end
    if (psum_in_en) begin n_ps++; p_last = int'(psum_in); end
    if (start_psum_in_load) n_pst++;
    if (psum_out_start) n_ost++;
    if (job_done) n_done++;
    if (cfg_err) n_err_p++;
    if (start_config) n_cfg++;
    if (start_feature_load && load_full_cloumn) n_fs_l++;
    if (start_feature_load && !load_full_cloumn) n_fs_n++;
    if (busy) n_busy++;
    if ((wgt_src_ready != weight_in_en) || (fmap_src_ready != feature_in_en) ||
        (psum_src_ready != psum_in_en)) rdy_bad++;
    @(posedge clk);
    #1;
    if (tw) w_seq++;
    if (tf) f_seq++;
    if (tp) p_seq++;
    fmap_src_data = DW'(f_seq); wgt_src_data = DW'(w_seq); psum_src_data = DW'(p_seq);
  endtask

  task automatic start_job(input job_t t);
    clear_counts();
    cfg_S = PW'(t.s); cfg_U = PW'(t.u); cfg_q = PW'(t.qq); cfg_p = PW'(t.pp);
    cfg_j = PW'(7); cfg_k = PW'(9); cfg_mode = (t.m != 0); cfg_n_slides = PW'(t.n);
    job_start = 1'b1;
    step();
    job_start = 1'b0;
  endtask

  task automatic run_job(input job_t t);
    int bound;
    bound = (t.err != 0) ? 6 : 1000;
    bp_on = (t.bp != 0);
    start_job(t);
    for (int c = 0; c < bound; c++) begin
      if (n_done != 0) break;
      step();
    end
    bp_on = 1'b0;
    fifo_full_fmap = 1'b0;
  endtask

  task automatic check_job(input job_t t, input string tag);
    check({tag, "_weights"},      n_w,     t.w);
    check({tag, "_feat_full"},    n_ff,    t.ff);
    check({tag, "_feat_part"},    n_fp,    t.fp);
    check({tag, "_psum_in"},      n_ps,    t.ps);
    check({tag, "_psum_strobe"},  n_pst,   t.pst);
    check({tag, "_out_strobe"},   n_ost,   t.ost);
    check({tag, "_job_done"},     n_done,  t.done);
    check({tag, "_cfg_err"},      n_err_p, t.err);
    check({tag, "_start_cfg"},    n_cfg,   (t.err != 0) ? 0 : 1);
    check({tag, "_fstart_lfc1"},  n_fs_l,  (t.err != 0) ? 0 : 1);
    check({tag, "_fstart_lfc0"},  n_fs_n,  (t.err != 0) ? 0 : t.n - 1);
    check({tag, "_last_weight"},  w_last,  t.w);
    check({tag, "_last_psum"},    p_last,  t.ps);
    check({tag, "_feat_order"},   f_bad,   0);
    check({tag, "_feat_when_full"}, n_bpv, 0);
    check({tag, "_ready_eq_en"},  rdy_bad, 0);
    check({tag, "_busy_after"},   int'(busy), 0);
    if (t.err != 0) check({tag, "_busy_cycles"}, n_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           S  U  q  p  m  n  bp   w  ff fp ps pst ost done err
    vec[0] = '{3, 1, 4, 3, 1, 2, 0,  36, 12, 4, 6, 2,  2,  1,   0};
    vec[1] = '{3, 1, 4, 3, 0, 1, 1,  36, 12, 0, 0, 0,  1,  1,   0};
    vec[2] = '{2, 2, 3, 2, 1, 3, 1,  12,  6,12, 6, 3,  3,  1,   0};
    vec[3] = '{3, 1, 0, 3, 1, 2, 0,   0,  0, 0, 0, 0,  0,  0,   1};
    vec[4] = '{2, 1, 2, 1, 0, 0, 0,   0,  0, 0, 0, 0,  0,  0,   1};
    vec[5] = '{1, 1, 1, 1, 0, 1, 0,   1,  1, 0, 0, 0,  1,  1,   0};

    rst = 1'b0; job_start = 1'b0; bp_on = 1'b0;
    cfg_S = '0; cfg_U = '0; cfg_q = '0; cfg_p = '0; cfg_j = '0; cfg_k = '0;
    cfg_mode = 1'b0; cfg_n_slides = '0;
    fmap_src_valid = 1'b1; wgt_src_valid = 1'b1; psum_src_valid = 1'b1;
    fifo_full_fmap = 1'b0; fifo_full_filter = 1'b0;
    mac_finish = 1'b0; psum_acc_finish = 1'b0; psum_out_valid = 1'b0;
    clear_counts();

    // Reset state.
    step(); step();
    check("rst_busy", int'(busy), 0);
    check("rst_weight_en", int'(weight_in_en), 0);
    check("rst_fmap_ready", int'(fmap_src_ready), 0);
    check("rst_psum_en", int'(psum_in_en), 0);
    check("rst_job_done", int'(job_done), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_S", int'(S), 0);
    check("rst_lfc", int'(load_full_cloumn), 0);
    rst = 1'b1;
    step();

    // Whole jobs with status inputs always asserted.
    mac_finish = 1'b1; psum_acc_finish = 1'b1; psum_out_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_job(vec[i]);
      check_job(vec[i], $sformatf("job%0d", i));
      step();
    end
    mac_finish = 1'b0; psum_acc_finish = 1'b0; psum_out_valid = 1'b0;

    // Reset in the middle of the weight load, then rerun the same job.
    start_job(vec[0]);
    for (int c = 0; c < 200 && n_w < 20; c++) step();
    check("mid_weights_before_rst", n_w, 20);
    rst = 1'b0;
    step();
    check("mid_no_xfer_in_rst", n_w, 20);
    check("mid_busy", int'(busy), 0);
    check("mid_S", int'(S), 0);
    check("mid_q", int'(q), 0);
    check("mid_mode", int'(mode), 0);
    check("mid_lfc", int'(load_full_cloumn), 0);
    check("mid_strobe", int'(start_weight_load), 0);
    check("mid_weight_en", int'(weight_in_en), 0);
    rst = 1'b1;
    step();
    mac_finish = 1'b1; psum_acc_finish = 1'b1; psum_out_valid = 1'b1;
    run_job(vec[0]);
    check_job(vec[0], "rerun");
    mac_finish = 1'b0; psum_acc_finish = 1'b0; psum_out_valid = 1'b0;
    step();

    // Stray mac_finish during WLOAD, then mode=0 goes straight to OSTART.
    start_job('{1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int c = 0; c < 50 && n_w < 1; c++) step();
    mac_finish = 1'b1;
    step();
    mac_finish = 1'b0;
    check("stray_weights", n_w, 2);
    for (int c = 0; c < 50 && n_ff < 2; c++) step();
    check("stray_features", n_ff, 2);
    repeat (5) step();
    check("stray_wait_no_ostart", n_ost, 0);
    check("stray_still_busy", int'(busy), 1);
    mac_finish = 1'b1;
    step();
    mac_finish = 1'b0;
    check("stray_ostart_not_yet", n_ost, 0);
    step();
    check("mode0_ostart_next", n_ost, 1);
    check("mode0_no_pstart", n_pst, 0);
    check("mode0_no_psum_in", n_ps, 0);
    psum_out_valid = 1'b1;
    for (int c = 0; c < 20 && n_done == 0; c++) step();
    psum_out_valid = 1'b0;
    check("stray_job_done", n_done, 1);
    step();
    check("stray_busy_after", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
    $finish;
  end

endmodule
